// File: rtl/fifo_fill_ctrl.sv
// Fill/drain sequencer: loads each byte FIFO from one memory word, then drains the
// whole bank in lockstep and flags when the MAC inputs are valid.
module fifo_fill_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned NUM_FIFOS  = 9,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_WIDTH = DATA_WIDTH * DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  input  logic                  mem_waitrequest,
  input  logic [WORD_WIDTH-1:0] mem_readdata,
  input  logic                  mem_readdatavalid,
  output logic [NUM_FIFOS-1:0]  fifo_wren,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic [NUM_FIFOS-1:0]  fifo_full,
  input  logic [NUM_FIFOS-1:0]  fifo_empty,
  output logic                  fifo_rden,
  output logic                  mac_clr,
  output logic                  mac_en,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned KW = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
  localparam int unsigned BW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [KW-1:0] KLast = KW'(NUM_FIFOS - 1);
  localparam logic [BW-1:0] BLast = BW'(DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StWrite, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [BW-1:0]         byte_q, byte_d;
  logic [BW-1:0]         drain_q, drain_d;
  logic [WORD_WIDTH-1:0] sh_q, sh_d;
  logic                  clr_q, clr_d;
  logic                  mac_en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      byte_q   <= '0;
      drain_q  <= '0;
      sh_q     <= '0;
      clr_q    <= 1'b0;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      byte_q   <= byte_d;
      drain_q  <= drain_d;
      sh_q     <= sh_d;
      clr_q    <= clr_d;
      mac_en_q <= fifo_rden;
    end
  end

  assign mac_en = mac_en_q;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    byte_d      = byte_q;
    drain_d     = drain_q;
    sh_d        = sh_q;
    clr_d       = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    fifo_wren   = '0;
    fifo_wdata  = '0;
    fifo_rden   = 1'b0;
    mac_clr     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        done = (state_q == StDone);
        if (start) begin
          k_d     = '0;
          byte_d  = '0;
          drain_d = '0;
          clr_d   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        busy        = 1'b1;
        mem_read    = 1'b1;
        mem_address = base_addr + ADDR_WIDTH'(k_q);
        // clr_q is only set on the cycle entering the sequence
        mac_clr     = clr_q;
        if (!mem_waitrequest) state_d = StWait;
      end
      StWait: begin
        busy = 1'b1;
        if (mem_readdatavalid) begin
          sh_d    = mem_readdata;
          state_d = StWrite;
        end
      end
      StWrite: begin
        busy       = 1'b1;
        fifo_wdata = sh_q[DATA_WIDTH-1:0];
        if (!fifo_full[k_q]) begin
          fifo_wren[k_q] = 1'b1;
          sh_d           = sh_q >> DATA_WIDTH;
          if (byte_q == BLast) begin
            byte_d = '0;
            if (k_q == KLast) begin
              state_d = StDrain;
            end else begin
              k_d     = k_q + 1'b1;
              state_d = StReq;
            end
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      StDrain: begin
        busy = 1'b1;
        if (!(|fifo_empty)) begin
          fifo_rden = 1'b1;
          if (drain_q == BLast) state_d = StDone;
          else drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Self-checking bench for fifo_fill_ctrl: behavioural memory and FIFO bank, timing
// predicted from the nominal schedule plus one cycle per injected stall.
module tb_fifo_fill_ctrl;

  localparam int DW       = 8;
  localparam int DEPTH    = 8;
  localparam int NF       = 9;
  localparam int AW       = 32;
  localparam int WW       = DW * DEPTH;
  localparam int NOM_DONE = 99;

  logic          clk = 1'b0;
  logic          rst, start, mem_read, mem_waitrequest, mem_readdatavalid;
  logic          fifo_rden, mac_clr, mac_en, busy, done;
  logic [AW-1:0] base_addr, mem_address;
  logic [WW-1:0] mem_readdata;
  logic [NF-1:0] fifo_wren, fifo_full, fifo_empty;
  logic [DW-1:0] fifo_wdata;

  always #5 clk = ~clk;

  fifo_fill_ctrl #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_FIFOS(NF), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
    .fifo_wren(fifo_wren), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_rden(fifo_rden), .mac_clr(mac_clr), .mac_en(mac_en),
    .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Scenario knobs
  int  wr_stall [NF];
  int  rdv_delay [NF];
  int  full_k, full_after, full_len, empty_k, empty_after, empty_len;
  int  extra_start_cyc, rst_cyc;
  bit  hold_rst;
  logic [WW-1:0] mem_words [NF];
  logic [AW-1:0] base;

  // Environment state and observations
  int  wr_used, full_left, empty_left;
  bit  full_fired, empty_fired, stalled_prev, rden_prev;
  logic [AW-1:0] addr_prev;
  int            ret_cyc_q [$];
  logic [WW-1:0] ret_data_q [$];
  logic [AW-1:0] acc_q [$];
  int            wcnt [NF];
  int            rcnt;
  logic [DW-1:0] wlog [NF][DEPTH];
  int wr_total, rd_total, me_total, clr_total, clr_first, extra_wr;
  int w0_first, w8_first, w8_last, rd_first, rd_last, me_first, me_last, done_cyc, last_act;

  task automatic init_seq();
    for (int i = 0; i < NF; i++) begin
      wr_stall[i]  = 0;
      rdv_delay[i] = 0;
      wcnt[i]      = 0;
      for (int j = 0; j < DEPTH; j++) wlog[i][j] = 'x;
    end
    full_k = 0; full_after = -1; full_len = 0; full_left = 0; full_fired = 0;
    empty_k = 0; empty_after = -1; empty_len = 0; empty_left = 0; empty_fired = 0;
    extra_start_cyc = -10; rst_cyc = -10; wr_used = 0; rcnt = 0;
    ret_cyc_q.delete(); ret_data_q.delete(); acc_q.delete();
    wr_total = 0; rd_total = 0; me_total = 0; clr_total = 0; clr_first = -1; extra_wr = 0;
    w0_first = -1; w8_first = -1; w8_last = -1; rd_first = -1; rd_last = -1;
    me_first = -1; me_last = -1; done_cyc = -1; last_act = -1;
  endtask

  task automatic set_words(input bit nominal);
    for (int k = 0; k < NF; k++)
      for (int j = 0; j < DEPTH; j++)
        mem_words[k][j*DW +: DW] = nominal ? DW'(k * 16 + 1 + j) : DW'($urandom);
  endtask

  // One clock: drive environment inputs, then observe outputs and update models.
  task automatic step();
    int idx;
    logic [AW-1:0] offl;
    @(posedge clk);
    #1;
    cyc++;
    rst   = hold_rst || (cyc == rst_cyc);
    start = (cyc == extra_start_cyc);
    idx   = (acc_q.size() < NF) ? acc_q.size() : NF - 1;
    mem_waitrequest   = mem_read && (wr_used < wr_stall[idx]);
    mem_readdatavalid = 1'b0;
    mem_readdata      = '0;
    if (ret_cyc_q.size() > 0) begin
      if (ret_cyc_q[0] == cyc) begin
        void'(ret_cyc_q.pop_front());
        mem_readdatavalid = 1'b1;
        mem_readdata      = ret_data_q.pop_front();
      end
    end
    for (int i = 0; i < NF; i++) begin
      fifo_full[i]  = (wcnt[i] - rcnt >= DEPTH) || (full_left > 0 && i == full_k);
      fifo_empty[i] = (wcnt[i] - rcnt <= 0) || (empty_left > 0 && i == empty_k);
    end
    #1;
    n_checks++;
    if (!$onehot0(fifo_wren)) begin
      n_fail++;
      $display("FAIL wren_onehot cyc=%0d wren=%b required one-hot or zero", cyc, fifo_wren);
    end
    n_checks++;
    if ((|fifo_wren) && fifo_rden) begin
      n_fail++;
      $display("FAIL wren_rden_excl cyc=%0d wren=%b rden=1 required rden=0", cyc, fifo_wren);
    end
    n_checks++;
    if (mac_en !== rden_prev) begin
      n_fail++;
      $display("FAIL mac_en_pipe cyc=%0d mac_en=%b required %b", cyc, mac_en, rden_prev);
    end
    n_checks++;
    if ((fifo_wren & fifo_full) != '0) begin
      n_fail++;
      $display("FAIL write_while_full cyc=%0d wren=%b full=%b", cyc, fifo_wren, fifo_full);
    end
    n_checks++;
    if (fifo_rden && (|fifo_empty)) begin
      n_fail++;
      $display("FAIL read_while_empty cyc=%0d rden=1 empty=%b required rden=0", cyc, fifo_empty);
    end
    if (stalled_prev) begin
      n_checks++;
      if (mem_read !== 1'b1 || mem_address !== addr_prev) begin
        n_fail++;
        $display("FAIL addr_stable cyc=%0d read=%b addr=%h required read=1 addr=%h",
                 cyc, mem_read, mem_address, addr_prev);
      end
    end
    if (cyc == rst_cyc + 1) begin
      n_checks++;
      if ({mem_address, mem_read, fifo_wren, fifo_wdata, fifo_rden, mac_clr, mac_en,
           busy, done} !== '0) begin
        n_fail++;
        $display("FAIL post_rst_outputs cyc=%0d busy=%b read=%b addr=%h required all 0",
                 cyc, busy, mem_read, mem_address);
      end
    end
    if (full_left > 0) full_left--;
    if (empty_left > 0) empty_left--;
    if (mem_read && !mem_waitrequest) begin
      offl = mem_address - base;
      ret_cyc_q.push_back(cyc + 1 + rdv_delay[idx]);
      ret_data_q.push_back((offl < NF) ? mem_words[int'(offl)] : '0);
      acc_q.push_back(mem_address);
      wr_used = 0;
    end else if (mem_read) begin
      wr_used++;
    end
    for (int i = 0; i < NF; i++) begin
      if (fifo_wren[i]) begin
        if (wcnt[i] < DEPTH) wlog[i][wcnt[i]] = fifo_wdata;
        else extra_wr++;
        wcnt[i]++;
        wr_total++;
        if (i == 0 && w0_first < 0) w0_first = cyc;
        if (i == NF - 1) begin
          if (w8_first < 0) w8_first = cyc;
          w8_last = cyc;
        end
        if (i == full_k && wcnt[i] == full_after && !full_fired) begin
          full_fired = 1;
          full_left  = full_len;
        end
      end
    end
    if (fifo_rden) begin
      rcnt++;
      rd_total++;
      if (rd_first < 0) rd_first = cyc;
      rd_last = cyc;
      if (rcnt == empty_after && !empty_fired) begin
        empty_fired = 1;
        empty_left  = empty_len;
      end
    end
    if (mac_en) begin
      me_total++;
      if (me_first < 0) me_first = cyc;
      me_last = cyc;
    end
    if (mac_clr) begin
      clr_total++;
      if (clr_first < 0) clr_first = cyc;
    end
    if (done && done_cyc < 0) done_cyc = cyc;
    if (busy || mem_read || (|fifo_wren) || fifo_rden || mac_en || mac_clr) last_act = cyc;
    stalled_prev = mem_read && mem_waitrequest;
    addr_prev    = mem_address;
    rden_prev    = fifo_rden;
  endtask

  task automatic run_seq(input int limit);
    base_addr = base;
    cyc       = 0;
    start     = 1'b1;
    while (done_cyc < 0 && cyc < limit) step();
  endtask

  task automatic test_reset();
    hold_rst = 1;
    step();
    hold_rst = 0;
    step();
    for (int i = 0; i <= 20; i++) begin
      n_checks++;
      if ({mem_address, mem_read, fifo_wren, fifo_wdata, fifo_rden, mac_clr, mac_en,
           busy, done} !== '0) begin
        n_fail++;
        $display("FAIL idle_outputs step=%0d busy=%b done=%b read=%b required all 0",
                 i, busy, done, mem_read);
      end
      if (i < 20) step();
    end
  endtask

  task automatic test_nominal();
    init_seq();
    base = 32'h100;
    set_words(1);
    run_seq(300);
    n_checks++;
    if (done_cyc != NOM_DONE) begin
      n_fail++; $display("FAIL nom_done got=%0d required=%0d", done_cyc, NOM_DONE);
    end
    n_checks++;
    if (acc_q.size() != NF) begin
      n_fail++; $display("FAIL nom_accepts got=%0d required=%0d", acc_q.size(), NF);
    end
    for (int k = 0; k < acc_q.size() && k < NF; k++) begin
      n_checks++;
      if (acc_q[k] !== base + AW'(k)) begin
        n_fail++; $display("FAIL nom_addr k=%0d got=%h required=%h", k, acc_q[k], base + AW'(k));
      end
    end
    for (int k = 0; k < NF; k++)
      for (int j = 0; j < DEPTH; j++) begin
        n_checks++;
        if (wlog[k][j] !== DW'(k * 16 + 1 + j)) begin
          n_fail++;
          $display("FAIL nom_byte fifo=%0d idx=%0d got=%h required=%h", k, j, wlog[k][j],
                   DW'(k * 16 + 1 + j));
        end
      end
    n_checks++;
    if ({w0_first, w8_first, w8_last, rd_first, rd_last, me_first, me_last} !==
        {32'd3, 32'd83, 32'd90, 32'd91, 32'd98, 32'd92, 32'd99}) begin
      n_fail++;
      $display("FAIL nom_timeline got w0=%0d w8=%0d..%0d rd=%0d..%0d me=%0d..%0d required 3 83..90 91..98 92..99",
               w0_first, w8_first, w8_last, rd_first, rd_last, me_first, me_last);
    end
    n_checks++;
    if (wr_total != NF * DEPTH || rd_total != DEPTH || me_total != DEPTH || extra_wr != 0) begin
      n_fail++;
      $display("FAIL nom_counts wr=%0d rd=%0d me=%0d extra=%0d required 72 8 8 0",
               wr_total, rd_total, me_total, extra_wr);
    end
    n_checks++;
    if (clr_total != 1 || clr_first != 1) begin
      n_fail++; $display("FAIL nom_mac_clr count=%0d at=%0d required 1 at 1", clr_total, clr_first);
    end
  endtask

  task automatic test_mem_stalls();
    for (int rep = 0; rep < 4; rep++) begin
      int exp_done;
      init_seq();
      set_words(0);
      base = (rep == 1) ? 32'hFFFF_FFFC : $urandom;
      if (rep == 0) begin
        wr_stall[2]  = 3;
        rdv_delay[5] = 4;
      end else begin
        for (int k = 0; k < NF; k++) begin
          wr_stall[k]  = $urandom_range(0, 2);
          rdv_delay[k] = $urandom_range(0, 3);
        end
      end
      exp_done = NOM_DONE;
      for (int k = 0; k < NF; k++) exp_done += wr_stall[k] + rdv_delay[k];
      run_seq(400);
      n_checks++;
      if (done_cyc != exp_done) begin
        n_fail++; $display("FAIL stall_done rep=%0d got=%0d required=%0d", rep, done_cyc, exp_done);
      end
      n_checks++;
      if (acc_q.size() != NF) begin
        n_fail++; $display("FAIL stall_accepts rep=%0d got=%0d required=%0d", rep, acc_q.size(), NF);
      end
      for (int k = 0; k < acc_q.size() && k < NF; k++) begin
        n_checks++;
        if (acc_q[k] !== base + AW'(k)) begin
          n_fail++; $display("FAIL stall_addr k=%0d got=%h required=%h", k, acc_q[k], base + AW'(k));
        end
      end
      for (int k = 0; k < NF; k++)
        for (int j = 0; j < DEPTH; j++) begin
          n_checks++;
          if (wlog[k][j] !== mem_words[k][j*DW +: DW]) begin
            n_fail++;
            $display("FAIL stall_byte fifo=%0d idx=%0d got=%h required=%h", k, j, wlog[k][j],
                     mem_words[k][j*DW +: DW]);
          end
        end
      n_checks++;
      if (me_total != DEPTH) begin
        n_fail++; $display("FAIL stall_mac_en got=%0d required=%0d", me_total, DEPTH);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int rep = 0; rep < 2; rep++) begin
      init_seq();
      set_words(0);
      base        = $urandom;
      full_k      = 4;
      full_after  = $urandom_range(1, DEPTH - 1);
      full_len    = 5;
      empty_k     = 0;
      empty_after = $urandom_range(1, DEPTH - 1);
      empty_len   = 2;
      run_seq(400);
      n_checks++;
      if (done_cyc != NOM_DONE + 7) begin
        n_fail++; $display("FAIL bp_done got=%0d required=%0d", done_cyc, NOM_DONE + 7);
      end
      for (int k = 0; k < NF; k++) begin
        n_checks++;
        if (wcnt[k] != DEPTH) begin
          n_fail++; $display("FAIL bp_wcount fifo=%0d got=%0d required=%0d", k, wcnt[k], DEPTH);
        end
        for (int j = 0; j < DEPTH; j++) begin
          n_checks++;
          if (wlog[k][j] !== mem_words[k][j*DW +: DW]) begin
            n_fail++;
            $display("FAIL bp_byte fifo=%0d idx=%0d got=%h required=%h", k, j, wlog[k][j],
                     mem_words[k][j*DW +: DW]);
          end
        end
      end
      n_checks++;
      if (rd_total != DEPTH || me_total != DEPTH) begin
        n_fail++; $display("FAIL bp_reads rd=%0d me=%0d required 8 8", rd_total, me_total);
      end
    end
  endtask

  task automatic test_control_edges();
    // start while busy is ignored
    init_seq();
    set_words(0);
    base            = $urandom;
    extra_start_cyc = $urandom_range(2, 90);
    run_seq(300);
    n_checks++;
    if (done_cyc != NOM_DONE || acc_q.size() != NF || clr_total != 1) begin
      n_fail++;
      $display("FAIL busy_start done=%0d accepts=%0d clr=%0d required 99 9 1",
               done_cyc, acc_q.size(), clr_total);
    end
    // reset at cycle 40 while FIFO 3's read is outstanding; its late data must be ignored
    init_seq();
    set_words(0);
    base         = $urandom;
    rdv_delay[3] = 10;
    rst_cyc      = 40;
    run_seq(60);
    n_checks++;
    if (done_cyc != -1 || last_act != 40 || acc_q.size() != 4 || wr_total != 3 * DEPTH) begin
      n_fail++;
      $display("FAIL mid_rst done=%0d last_act=%0d accepts=%0d wr=%0d required -1 40 4 24",
               done_cyc, last_act, acc_q.size(), wr_total);
    end
    // full run, then restart straight from DONE with a new base
    init_seq();
    set_words(0);
    base = $urandom;
    run_seq(300);
    n_checks++;
    if (done_cyc != NOM_DONE) begin
      n_fail++; $display("FAIL pre_restart_done got=%0d required=%0d", done_cyc, NOM_DONE);
    end
    init_seq();
    set_words(0);
    base = $urandom;
    run_seq(300);
    n_checks++;
    if (clr_first != 1 || clr_total != 1 || done_cyc != NOM_DONE) begin
      n_fail++;
      $display("FAIL restart clr_at=%0d clr=%0d done=%0d required 1 1 99",
               clr_first, clr_total, done_cyc);
    end
    n_checks++;
    if (acc_q.size() == 0 || acc_q[0] !== base) begin
      n_fail++;
      $display("FAIL restart_addr accepts=%0d required first addr=%h", acc_q.size(), base);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0;
    mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;
    fifo_full = '0; fifo_empty = '1;
    stalled_prev = 0; rden_prev = 0; addr_prev = '0; base = '0;
    init_seq();
    set_words(1);
    test_reset();
    test_nominal();
    test_mem_stalls();
    test_backpressure();
    test_control_edges();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_fill_ctrl.md
# fifo_fill_ctrl

Sequencer that loads a bank of byte-wide FIFOs from a word-wide memory, then drains them in lockstep into the MAC array. For each FIFO it issues one memory read, unpacks the returned word into DEPTH bytes, and writes them into that FIFO. When every FIFO is filled, it broadcasts DEPTH read strobes and flags when the downstream MAC inputs are valid. It sits between the memory read port and the FIFO bank / MAC datapath and is the only writer and reader of the FIFO bank.

## Interface
- DATA_WIDTH, 8: FIFO entry width in bits.
- DEPTH, 8: FIFO depth; also the number of bytes per memory word.
- NUM_FIFOS, 9: FIFOs in the bank; 8 matrix rows plus 1 vector.
- ADDR_WIDTH, 32: memory address width.
- WORD_WIDTH, DATA_WIDTH*DEPTH: memory data width. Derived; do not override.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a full fill/drain sequence.
- base_addr  in  ADDR_WIDTH  word address of FIFO 0's data. FIFO k uses base_addr+k.
- mem_address  out  ADDR_WIDTH  read address.
- mem_read  out  1  read request.
- mem_waitrequest  in  1  memory stall; the request is accepted on a cycle with mem_read=1 and waitrequest=0.
- mem_readdata  in  WORD_WIDTH  returned word.
- mem_readdatavalid  in  1  mem_readdata is valid this cycle.
- fifo_wren  out  NUM_FIFOS  one-hot write enable; bit k targets FIFO k.
- fifo_wdata  out  DATA_WIDTH  write data, shared by all FIFOs.
- fifo_full  in  NUM_FIFOS  per-FIFO full flags.
- fifo_empty  in  NUM_FIFOS  per-FIFO empty flags.
- fifo_rden  out  1  read enable, broadcast to all FIFOs.
- mac_clr  out  1  one-cycle accumulator clear.
- mac_en  out  1  FIFO outputs are valid for the MAC this cycle.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high while in DONE.

## Operation
- States: IDLE, REQ, WAIT, WRITE, DRAIN, DONE.
- Counters:
  - fifo index k: 0..NUM_FIFOS-1.
  - byte count b: 0..DEPTH-1.
  - drain count d: 0..DEPTH-1.
- Shift register sh is WORD_WIDTH wide.
- IDLE or DONE, start=1:
  - k, b, d cleared to 0.
  - Next state REQ; mac_clr=1 during that first REQ cycle only.
- start is ignored in all other states.
- REQ:
  - mem_read=1, mem_address=base_addr+k. Addition is modulo 2^ADDR_WIDTH.
  - Hold both outputs stable while mem_waitrequest=1.
  - On acceptance, go to WAIT; mem_read=0 from the next cycle.
- WAIT:
  - mem_read=0.
  - On mem_readdatavalid: sh<=mem_readdata and go to WRITE.
  - Any number of wait cycles is allowed.
- WRITE:
  - fifo_wdata=sh[DATA_WIDTH-1:0], so byte 0 (the LSBs) is written first.
  - fifo_wren[k]=1 only when fifo_full[k]=0.
  - On a write: sh shifts right by DATA_WIDTH and b increments.
  - If fifo_full[k]=1: no write, no shift, stall.
  - After the write with b=DEPTH-1:
    - If k=NUM_FIFOS-1, go to DRAIN.
    - Otherwise k++, b=0, and go to REQ.
- DRAIN:
  - fifo_rden=1 only when fifo_empty is all zeros; d increments per read.
  - Any FIFO empty stalls the drain; fifo_rden=0 while stalled.
  - After the read with d=DEPTH-1, go to DONE.
- mac_en = fifo_rden registered by one cycle. This matches the FIFO's 1-cycle read latency.
- DONE: done=1 and busy=0. Stay here until start or rst.
- Outputs that are not driven active in a state are 0.
- fifo_wren is never multi-hot. fifo_wren and fifo_rden are never both active.

## Timing
- Reset: after rst, the state is IDLE and every output is 0, including mem_address, fifo_wdata and the mac_en pipeline register. Counters and sh are cleared.
- rst mid-sequence aborts on the next edge; the outstanding read's readdatavalid is ignored in IDLE. FIFO contents are not cleared by this block.
- Per-FIFO latency, with zero waitrequest and readdatavalid one cycle after acceptance: 1 REQ + 1 WAIT + DEPTH WRITE = 10 cycles.
- Full sequence with defaults and no stalls, start sampled at cycle 0:
  - REQ at cycle 1 (mac_clr=1).
  - FIFO 0 writes at cycles 3..10.
  - FIFO 8 writes at cycles 83..90.
  - fifo_rden at cycles 91..98.
  - mac_en at cycles 92..99.
  - done rises at cycle 99.
- Each waitrequest, readdatavalid delay, full stall or empty stall adds exactly one cycle per stall cycle.
- start and rst in the same cycle: rst wins.
- start in DONE restarts the sequence immediately: done=0 the next cycle and mac_clr is pulsed.

## Test plan
- Reset and idle: hold rst for 2 cycles, then idle → all outputs 0, busy=0, done=0; start held 0 for 20 cycles → no activity.
- Nominal: base_addr=0x100, word k = bytes (k*16+1 .. k*16+8) LSB first, memory with no waits → addresses 0x100..0x108 in order; FIFO k receives k*16+1..k*16+8 in order; counts match the full-sequence cycles above; done at cycle 99.
- Memory stalls: waitrequest high for 3 cycles on the FIFO 2 request, readdatavalid delayed 4 cycles on FIFO 5 → mem_address stable while stalled, exactly one mem_read acceptance per FIFO, done at cycle 106.
- Backpressure: fifo_full[4] forced high for 5 cycles mid-WRITE, fifo_empty[0] high for 2 cycles in DRAIN → no wren or rden during stalls, no bytes lost or duplicated, mac_en pulses total exactly 8.
- Control edges: start while busy → ignored; rst at cycle 40 → IDLE with outputs 0 next cycle, late readdatavalid ignored; start in DONE → mac_clr pulse and restart at base_addr.
- Checker (every cycle): fifo_wren one-hot or zero, never concurrent with fifo_rden; mac_en equals fifo_rden delayed by one cycle.
